// File: rtl/mem_axi_bridge_pkg.sv
// Shared types and constants for the cache-to-AXI bridge.
// Holds the bridge state encoding and the write-strobe helper.
package mem_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RADDR,
    ST_RDATA,
    ST_WADDR,
    ST_WRESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  function automatic logic [3:0] size_to_wstrb(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic [3:0] s;
    s = 4'hf;
    unique case (size)
      2'd0: s = 4'b0001 << addr;
      2'd1: s = addr[1] ? 4'b1100 : 4'b0011;
      default: s = 4'hf;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_axi_bridge_arbiter.sv
// Two-port round-robin arbiter for the bridge.
// Produces a one-hot grant, only while the bridge is idle.
module mem_axi_arbiter (
  input  logic       i_idle,
  input  logic       i_en0,
  input  logic       i_en1,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_idle) begin
      if (i_en0 && i_en1)
        o_grant = i_last ? 2'b01 : 2'b10;
      else
        o_grant = {i_en1, i_en0};
    end
  end

endmodule

// File: rtl/mem_axi_bridge.sv
// Arbitrates the D/I cache memory ports onto one AXI master.
// Every cache request becomes a single-beat AXI read or write.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter logic [3:0] P0_ID = 4'd1,
  parameter logic [3:0] P1_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_en,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_data_w,
  output logic [31:0] p0_data_r,
  output logic        p0_addr_o,
  output logic        p0_data_o,
  input  logic        p1_en,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_data_w,
  output logic [31:0] p1_data_r,
  output logic        p1_addr_o,
  output logic        p1_data_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic [7:0]  awlen,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_port;
  logic        r_we;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        r_aw_done;
  logic        r_w_done;
  logic [1:0]  w_grant;
  logic        w_sel_we;
  logic        w_addr_hs;
  logic        w_data_hs;
  logic        w_rd_hit;
  logic        w_unused;

  mem_axi_arbiter u_arb (
    .i_idle  (r_state == ST_IDLE),
    .i_en0   (p0_en),
    .i_en1   (p1_en),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_sel_we = w_grant[1] ? p1_we : p0_we;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_port    <= 1'b0;
      r_we      <= 1'b0;
      r_size    <= 2'd0;
      r_addr    <= '0;
      r_data    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (|w_grant) begin
        r_port    <= w_grant[1];
        r_last    <= w_grant[1];
        r_we      <= w_sel_we;
        r_size    <= w_grant[1] ? p1_size : p0_size;
        r_addr    <= w_grant[1] ? p1_addr : p0_addr;
        r_data    <= w_grant[1] ? p1_data_w : p0_data_w;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else if (r_state == ST_WADDR) begin
        if (awvalid && awready) r_aw_done <= 1'b1;
        if (wvalid && wready)   r_w_done  <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    w_addr_hs = 1'b0;
    w_data_hs = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (|w_grant)
          w_next = w_sel_we ? ST_WADDR : ST_RADDR;
      end
      ST_RADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_addr_hs = 1'b1;
          w_next    = ST_RDATA;
        end
      end
      ST_RDATA: begin
        rready = 1'b1;
        if (rvalid) begin
          w_data_hs = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_WADDR: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        // address accepted once both AW and W have handshaken
        if ((r_aw_done || awready) && (r_w_done || wready)) begin
          w_addr_hs = 1'b1;
          w_next    = ST_WRESP;
        end
      end
      ST_WRESP: begin
        bready = 1'b1;
        if (bvalid) begin
          w_data_hs = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_rd_hit  = w_data_hs && (r_state == ST_RDATA);
  assign p0_addr_o = w_addr_hs & ~r_port;
  assign p1_addr_o = w_addr_hs & r_port;
  assign p0_data_o = w_data_hs & ~r_port;
  assign p1_data_o = w_data_hs & r_port;
  assign p0_data_r = (w_rd_hit && !r_port) ? rdata : '0;
  assign p1_data_r = (w_rd_hit && r_port) ? rdata : '0;

  assign arid    = r_port ? P1_ID : P0_ID;
  assign awid    = r_port ? P1_ID : P0_ID;
  assign araddr  = r_addr;
  assign awaddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign awsize  = {1'b0, r_size};
  assign arlen   = LEN_SINGLE;
  assign awlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign wdata   = r_data;
  assign wstrb   = size_to_wstrb(r_size, r_addr[1:0]);
  assign wlast   = 1'b1;

  assign w_unused = ^{rid, rresp, rlast, bid, bresp, r_we};

endmodule
